// File: rtl/filter_pkg.sv
// Shared types for the filter-instruction dispatch path.
package filter_pkg;

  localparam int unsigned INST_W   = 15;
  localparam int unsigned TAG_BIT  = 0;
  localparam int unsigned ROW_LSB  = TAG_BIT + 1;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned LAST_BIT = INST_W - 1;
  localparam int unsigned RSVD_W   = LAST_BIT - ROW_LSB - ROW_W;

  typedef struct packed {
    logic              last;
    logic [RSVD_W-1:0] rsvd;
    logic [ROW_W-1:0]  row;
    logic              tag;
  } filter_inst_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SEND
  } disp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count; full/empty derive from it.
module sync_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/filter_inst_dispatcher.sv
// Buffers filter instructions, fetches each addressed row from filter memory and hands it to the PE array.
module filter_inst_dispatcher
  import filter_pkg::*;
#(
  parameter int unsigned WIDTH      = 15,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned FIL_BASE   = 0,
  parameter int unsigned ROW_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic [2:0]        pe_dest,
  output logic [DATA_W-1:0] pe_data,
  output logic              done,
  output logic              err
);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  filter_inst_t     head;
  logic             unused_rsvd;

  disp_state_t       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              pe_valid_q, pe_valid_d;
  logic [2:0]        pe_dest_q, pe_dest_d;
  logic [DATA_W-1:0] pe_data_q, pe_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // No pass-through: readiness depends only on the registered occupancy.
  assign in_ready  = ~rst & ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head        = filter_inst_t'(fifo_rdata[INST_W-1:0]);
  assign unused_rsvd = ^head.rsvd;

  // Next-state and datapath: one instruction in flight, pops only while idle.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    pe_valid_d = pe_valid_q;
    pe_dest_d  = pe_dest_q;
    pe_data_d  = pe_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head.tag) begin
            err_d = 1'b1;
          end else begin
            row_d      = head.row;
            last_d     = head.last;
            mem_addr_d = ADDR_W'(32'(FIL_BASE) + 32'(head.row) * 32'(ROW_STRIDE));
            mem_req_d  = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          pe_data_d  = mem_rdata;
          pe_dest_d  = row_q;
          pe_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (pe_ready) begin
          pe_valid_d = 1'b0;
          done_d     = last_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      last_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      pe_valid_q <= 1'b0;
      pe_dest_q  <= '0;
      pe_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      pe_valid_q <= pe_valid_d;
      pe_dest_q  <= pe_dest_d;
      pe_data_q  <= pe_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pe_valid = pe_valid_q;
  assign pe_dest  = pe_dest_q;
  assign pe_data  = pe_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
